grepsic_core: RTL and testbench

// - Streaming "grep in silicon" engine, the core behind the Tiny Tapeout top tt_um_rtfb_grepsic.
// - The host loads a short literal pattern (with '.' wildcard), then streams text bytes one per cycle.
// - A shift-and (bitap) NFA flags substring matches, per-line match status and a count of matching lines.

---
 rtl/grepsic_pkg.sv | 18 +
 rtl/grepsic_char_match.sv | 18 +
 rtl/grepsic_core.sv | 100 ++++++++++
 tb/tb_grepsic_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/grepsic_pkg.sv
// Shared constants, types and the case-fold helper for the grepsic streaming matcher.
package grepsic_pkg;

    localparam int          NPAT_DEFAULT = 8;
    localparam logic [7:0]  CH_WILD      = 8'h2E;
    localparam logic [7:0]  CH_NL        = 8'h0A;
    localparam int          LCNT_W       = 4;

    typedef logic [7:0] pat_char_t;

    function automatic pat_char_t fold_case(input pat_char_t c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c | 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/grepsic_char_match.sv
// One pattern position: compares a stored pattern byte against the current text byte.
// With GREPSIC_NOCASE_EN defined, letters are folded to lower case before the compare.
module grepsic_char_match
    import grepsic_pkg::*;
(
    input  logic [7:0] pat_char,
    input  logic [7:0] txt_char,
    input  logic       valid,
    output logic       eq
);

`ifdef GREPSIC_NOCASE_EN
    assign eq = valid && ((pat_char == CH_WILD) || (fold_case(pat_char) == fold_case(txt_char)));
`else
    assign eq = valid && ((pat_char == CH_WILD) || (pat_char == txt_char));
`endif

endmodule

// File: rtl/grepsic_core.sv
// Streaming shift-and (bitap) substring matcher with per-line match flag and matching-line count.
// Optional case-insensitive compare when GREPSIC_NOCASE_EN is defined.
module grepsic_core
    import grepsic_pkg::*;
#(
    parameter int NPAT = NPAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    pat_char_t         pat [NPAT];
    logic [3:0]        pat_len;
    logic [NPAT-1:0]   d;
    logic [NPAT-1:0]   eq;
    logic [NPAT-1:0]   d_next;
    logic              match;
    logic              line_match;
    logic [LCNT_W-1:0] line_cnt;
    logic              hit;

    logic pat_wr, txt_wr, pat_clr;
    assign pat_wr  = uio_in[0];
    assign txt_wr  = uio_in[1];
    assign pat_clr = uio_in[2];

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};

    for (genvar g = 0; g < NPAT; g++) begin : g_cm
        grepsic_char_match u_cm (
            .pat_char (pat[g]),
            .txt_char (ui_in),
            .valid    (pat_len > 4'(g)),
            .eq       (eq[g])
        );
    end

    assign d_next = ((d << 1) | NPAT'(1)) & eq;

    // Only the bit at the current pattern end reports a full match.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NPAT; i++) begin
            if (pat_len == 4'(i + 1)) begin
                hit = d_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_len    <= '0;
            d          <= '0;
            match      <= 1'b0;
            line_match <= 1'b0;
            line_cnt   <= '0;
            for (int i = 0; i < NPAT; i++) begin
                pat[i] <= '0;
            end
        end else if (ena) begin
            match <= 1'b0;
            if (pat_clr) begin
                pat_len    <= '0;
                d          <= '0;
                line_match <= 1'b0;
            end else if (pat_wr) begin
                if (pat_len < 4'(NPAT)) begin
                    pat[pat_len[$clog2(NPAT)-1:0]] <= ui_in;
                    pat_len <= pat_len + 4'd1;
                end
                d          <= '0;
                line_match <= 1'b0;
            end else if (txt_wr) begin
                if (ui_in == CH_NL) begin
                    if (line_match && line_cnt != '1) begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                    d          <= '0;
                    line_match <= 1'b0;
                end else begin
                    d          <= d_next;
                    match      <= hit;
                    line_match <= line_match | hit;
                end
            end
        end
    end

    assign uo_out  = {line_cnt, (pat_len == 4'd0), (pat_len == 4'(NPAT)), line_match, match};
    assign uio_out = {pat_len, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_grepsic_core.sv
// Self-checking bench for grepsic_core: directed vector table, corner sequences, random vs reference model.
module tb_grepsic_core;
    import grepsic_pkg::*;

    localparam logic [2:0] PW = 3'b001;
    localparam logic [2:0] TW = 3'b010;
    localparam logic [2:0] CL = 3'b100;

    logic       clk = 1'b0;
    logic       rst, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    grepsic_core #(.NPAT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model: keeps the text seen since the last D-clearing event and checks the window.
    byte m_pat [8];
    int  m_len;
    byte m_hist [$];
    bit  m_match, m_lm;
    int  m_cnt;

    function automatic byte fc(input byte c);
`ifdef GREPSIC_NOCASE_EN
        if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
`endif
        return c;
    endfunction

    function automatic bit window_hit();
        int n;
        n = m_hist.size();
        if (m_len == 0 || n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (!(m_pat[k] == 8'h2E || fc(m_pat[k]) == fc(m_hist[n - m_len + k]))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic [2:0] s, input logic [7:0] b);
        if (r) begin
            m_len = 0; m_hist.delete(); m_match = 0; m_lm = 0; m_cnt = 0;
        end else if (e) begin
            m_match = 0;
            if (s[2]) begin
                m_len = 0; m_hist.delete(); m_lm = 0;
            end else if (s[0]) begin
                if (m_len < 8) begin m_pat[m_len] = byte'(b); m_len++; end
                m_hist.delete(); m_lm = 0;
            end else if (s[1]) begin
                if (b == 8'h0A) begin
                    if (m_lm && m_cnt < 15) m_cnt++;
                    m_hist.delete(); m_lm = 0;
                end else begin
                    m_hist.push_back(byte'(b));
                    if (m_hist.size() > 8) void'(m_hist.pop_front());
                    m_match = window_hit();
                    m_lm = m_lm | m_match;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] s, input logic [7:0] b);
        rst = r; ena = e; uio_in = {5'b0, s}; ui_in = b;
        @(posedge clk);
        model_update(r, e, s, b);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] s;
        logic [7:0] b;
        logic [7:0] uo;
        logic [3:0] len;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic r, input logic e, input logic [2:0] s,
                                input logic [7:0] b, input logic [7:0] uo, input logic [3:0] len);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.b = b; v.uo = uo; v.len = len;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

        // uo = {line_cnt, empty, full, line_match, match}
        add(1, 1, 3'b0, 8'h00, 8'h08, 4'd0);
        add(0, 1, PW,   "a",   8'h00, 4'd1);
        add(0, 1, PW,   "b",   8'h00, 4'd2);
        add(0, 1, TW,   "x",   8'h00, 4'd2);
        add(0, 1, TW,   "a",   8'h00, 4'd2);
        add(0, 1, TW,   "b",   8'h03, 4'd2);
        add(0, 1, TW,   "y",   8'h02, 4'd2);
        add(0, 1, TW,   "a",   8'h02, 4'd2);
        add(0, 1, TW,   "b",   8'h03, 4'd2);
        add(0, 1, TW,   8'h0A, 8'h10, 4'd2);
        add(0, 1, 3'b0, 8'h00, 8'h10, 4'd2);
        add(0, 1, CL,   8'h00, 8'h18, 4'd0);
        add(0, 1, PW|TW, "q",  8'h10, 4'd1);
        add(0, 0, PW,   "z",   8'h10, 4'd1);
        add(0, 0, CL,   8'h00, 8'h10, 4'd1);
        add(0, 1, TW,   "q",   8'h13, 4'd1);
        add(0, 1, 3'b0, 8'h00, 8'h12, 4'd1);
        add(0, 1, TW,   "z",   8'h12, 4'd1);
        add(1, 1, PW,   "a",   8'h08, 4'd0);
        add(0, 1, TW,   "a",   8'h08, 4'd0);
        add(0, 1, TW,   "b",   8'h08, 4'd0);
        add(0, 1, TW,   8'h0A, 8'h08, 4'd0);
        add(0, 1, PW,   "a",   8'h00, 4'd1);
        add(0, 1, PW,   ".",   8'h00, 4'd2);
        add(0, 1, PW,   "c",   8'h00, 4'd3);
        add(0, 1, TW,   "a",   8'h00, 4'd3);
        add(0, 1, TW,   "b",   8'h00, 4'd3);
        add(0, 1, TW,   "c",   8'h03, 4'd3);
        add(0, 1, TW,   8'h0A, 8'h10, 4'd3);
        add(0, 1, CL,   8'h00, 8'h18, 4'd0);
        add(0, 1, PW,   "a",   8'h10, 4'd1);
        add(0, 1, PW,   "a",   8'h10, 4'd2);
        add(0, 1, TW,   "a",   8'h10, 4'd2);
        add(0, 1, TW,   "a",   8'h13, 4'd2);
        add(0, 1, TW,   "a",   8'h13, 4'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].b);
            check($sformatf("vec%0d_uo", i), uo_out, tbl[i].uo);
            check($sformatf("vec%0d_len", i), uio_out, {tbl[i].len, 4'b0});
        end
        check("uio_oe", uio_oe, 8'hF0);

        // Nine pattern bytes into an 8-deep pattern: the ninth is dropped.
        step(0, 1, CL, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, PW, 8'h61 + 8'(i));
        check("full_len", uio_out, 8'h80);
        check("full_flag", {7'b0, uo_out[2]}, 8'h01);
        step(0, 1, TW, "i");
        check("ninth_ignored", {7'b0, uo_out[0]}, 8'h00);
        step(0, 1, CL, 8'h00);
        check("clr_empty", {6'b0, uo_out[3:2]}, 8'h02);

        // Sixteen matching lines saturate the counter.
        step(1, 1, 3'b0, 8'h00);
        step(0, 1, PW, "q");
        for (int i = 0; i < 16; i++) begin
            step(0, 1, TW, "q");
            step(0, 1, TW, 8'h0A);
        end
        check("line_cnt_sat", {4'b0, uo_out[7:4]}, 8'h0F);

`ifdef GREPSIC_NOCASE_EN
        step(1, 1, 3'b0, 8'h00);
        step(0, 1, PW, "A");
        step(0, 1, PW, "b");
        step(0, 1, TW, "a");
        step(0, 1, TW, "B");
        check("nocase_match", {7'b0, uo_out[0]}, 8'h01);
`endif

        // Randomized traffic against the reference model.
        step(1, 1, 3'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            logic       r, e;
            logic [2:0] s;
            logic [7:0] b;
            int         p;
            byte        alpha [5];
            alpha[0] = "a"; alpha[1] = "b"; alpha[2] = "."; alpha[3] = 8'h0A; alpha[4] = "A";
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            p = $urandom_range(0, 99);
            if (p < 3)       s = CL | 3'($urandom_range(0, 3));
            else if (p < 15) s = PW | (3'($urandom_range(0, 1)) << 1);
            else if (p < 90) s = TW;
            else             s = 3'b000;
            b = alpha[$urandom_range(0, (s == TW && $urandom_range(0, 5) == 0) ? 3 : 2)];
            if ($urandom_range(0, 9) == 0) b = alpha[4];
            step(r, e, s, b);
            check($sformatf("rnd%0d_uo", i), uo_out,
                  {4'(m_cnt), (m_len == 0), (m_len == 8), m_lm, m_match});
            check($sformatf("rnd%0d_len", i), uio_out, {4'(m_len), 4'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
